// File: rtl/mul_share_arbiter.sv
// Purpose : round-robin arbiter that time-shares one pipelined multiplier among NREQ requesters.
// Latency : LATENCY+1 cycles from accept to rsp_valid; one accept and one result per cycle.
// Backpr. : req_ready one-hot, withheld from a requester while its op is in flight; no result backpressure.
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (NREQ bits each)
//   req_a, req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a, mul_b          registered operands to the shared multiplier
//   mul_mm                multiplier product, valid LATENCY cycles after the operands
//   rsp_valid/id/data     one-cycle result strobe, owner index and registered product
//   busy                  per-requester outstanding flag
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 35,
    parameter int LATENCY = 6,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_mm,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic [NREQ-1:0]         busy
);

    // Last granted requester; the search for the next grant starts one past it.
    logic [IDW-1:0]  ptr;

    // Combinational grant decision for the current cycle.
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] eligible;

    // Tag travelling alongside the operands held in mul_a/mul_b.
    logic            op_vld;
    logic [IDW-1:0]  op_id;

    // Tag shift register matching the multiplier pipeline depth. Together with
    // the op_* stage this puts the tag at the tail exactly when mul_mm carries
    // the matching product, so rsp_* can register both on the same edge.
    logic            tag_vld [LATENCY];
    logic [IDW-1:0]  tag_id  [LATENCY];

    logic            tail_vld;
    logic [IDW-1:0]  tail_id;
    logic [NREQ-1:0] busy_nxt;

    assign tail_vld = tag_vld[LATENCY-1];
    assign tail_id  = tag_id[LATENCY-1];

    // A requester with an op in flight is not eligible; busy is cleared on the
    // same edge that raises rsp_valid, so it is eligible again in the strobe cycle.
    assign eligible = req_valid & ~busy;

    // Round-robin search starting at ptr+1, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    // Ready is gated by reset so nothing appears to be accepted while the
    // block is held in reset with requesters asserting valid.
    always_comb begin
        req_ready = '0;
        if (grant_vld && reset) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // The completing requester and the newly granted one can never coincide:
    // a grant needs busy low, a completion implies busy high.
    always_comb begin
        busy_nxt = busy;
        if (tail_vld) begin
            busy_nxt[tail_id] = 1'b0;
        end
        if (grant_vld) begin
            busy_nxt[grant_id] = 1'b1;
        end
    end

    // Operand registers, pointer and busy flags. Operands hold when nothing is
    // accepted so the multiplier sees stable inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= IDW'(NREQ - 1);
            mul_a  <= '0;
            mul_b  <= '0;
            busy   <= '0;
            op_vld <= 1'b0;
            op_id  <= '0;
        end else begin
            if (grant_vld) begin
                ptr   <= grant_id;
                mul_a <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                mul_b <= req_b[int'(grant_id)*WIDTH +: WIDTH];
            end
            op_vld <= grant_vld;
            op_id  <= grant_id;
            busy   <= busy_nxt;
        end
    end

    // Tag pipeline. The multiplier itself is not reset, so clearing these
    // tags is what discards any ops in flight when reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_id[i]  <= '0;
            end
        end else begin
            tag_vld[0] <= op_vld;
            tag_id[0]  <= op_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Result register: strobe for one cycle per completed op, data held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tail_vld;
            if (tail_vld) begin
                rsp_id   <= tail_id;
                rsp_data <= mul_mm;
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Purpose : randomized and directed bench for mul_share_arbiter against a transaction-level model.
// Latency : model expects each result exactly LATENCY+1 edges after its accept edge.
// Backpr. : model tracks one outstanding op per requester and round-robin grant order.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 35;
    localparam int L    = 6;
    localparam int IDW  = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic [W-1:0]          mul_a;
    logic [W-1:0]          mul_b;
    logic [2*W-1:0]        mul_mm;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [2*W-1:0]        rsp_data;
    logic [NREQ-1:0]       busy;

    mul_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .LATENCY(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_mm    (mul_mm),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: product of the operands L cycles later, never reset.
    logic [2*W-1:0] mpipe [L];
    initial for (int i = 0; i < L; i++) mpipe[i] = '0;
    always @(posedge clk) begin
        mpipe[0] <= mul_a * mul_b;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_mm = mpipe[L-1];

    // Reference model state.
    int              tot;
    int              bad;
    int              edge_n;
    int              m_ptr;
    logic [NREQ-1:0] m_busy;
    logic [W-1:0]    m_mul_a;
    logic [W-1:0]    m_mul_b;
    int              sb_id  [$];
    logic [2*W-1:0]  sb_p   [$];
    int              sb_due [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [NREQ*W-1:0] rand_ops();
        logic [NREQ*W-1:0] r;
        for (int i = 0; i < NREQ; i++) begin
            case ($urandom_range(0, 7))
                0:       r[i*W +: W] = '1;
                1:       r[i*W +: W] = '0;
                default: r[i*W +: W] = W'({$urandom(), $urandom()});
            endcase
        end
        return r;
    endfunction

    // One clock cycle: apply inputs, check ready against the model's grant,
    // take the edge, then check the registered outputs.
    task automatic cycle_step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                              input logic [NREQ*W-1:0] b);
        int              g;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    ga;
        logic [W-1:0]    gb;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        #1;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && v[idx] && !m_busy[idx]) g = idx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
            ga = a[g*W +: W];
            gb = b[g*W +: W];
            sb_id.push_back(g);
            sb_p.push_back({{W{1'b0}}, ga} * {{W{1'b0}}, gb});
            sb_due.push_back(edge_n + 1 + L + 1);
            m_ptr   = g;
            m_mul_a = ga;
            m_mul_b = gb;
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (sb_due.size() > 0 && sb_due[0] == edge_n) begin
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_id", rsp_id, sb_id[0]);
            check("rsp_data", rsp_data, sb_p[0]);
            m_busy[sb_id[0]] = 1'b0;
            void'(sb_id.pop_front());
            void'(sb_p.pop_front());
            void'(sb_due.pop_front());
        end else begin
            check("rsp_idle", rsp_valid, 1'b0);
        end
        if (g >= 0) m_busy[g] = 1'b1;
        check("busy", busy, m_busy);
        check("mul_a", mul_a, m_mul_a);
        check("mul_b", mul_b, m_mul_b);
    endtask

    // Reset for one cycle with requesters asserting valid; every output must
    // show its reset value immediately, and in-flight work is forgotten.
    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '1;
        req_a     = rand_ops();
        req_b     = rand_ops();
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_busy", busy, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_mul_a", mul_a, '0);
        check("rst_mul_b", mul_b, '0);
        sb_id.delete();
        sb_p.delete();
        sb_due.delete();
        m_busy  = '0;
        m_ptr   = NREQ - 1;
        m_mul_a = '0;
        m_mul_b = '0;
        @(posedge clk);
        edge_n++;
        #1;
        check("rst_hold_rsp", rsp_valid, 1'b0);
        check("rst_hold_ready", req_ready, '0);
        req_valid = '0;
        reset     = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_step('0, rand_ops(), rand_ops());
    endtask

    initial begin
        logic [NREQ*W-1:0] a;
        logic [NREQ*W-1:0] b;
        tot       = 0;
        bad       = 0;
        edge_n    = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #2;
        do_reset();

        // Single op from requester 0 with a known product.
        a = '0;
        b = '0;
        a[0 +: W] = W'(35'h5abcd);
        b[0 +: W] = W'(35'h7adef);
        cycle_step(4'b0001, a, b);
        idle(9);
        check("known_product", rsp_data, 70'h2B8CFFED63);
        check("known_id", rsp_id, 2'd0);

        // All requesters valid continuously: 0,1,2,3 then regrants on completion.
        do_reset();
        for (int i = 0; i < 20; i++) cycle_step(4'b1111, rand_ops(), rand_ops());
        idle(10);

        // Pointer at 1, requesters 0 and 3 valid: 3 wins, then 0.
        do_reset();
        cycle_step(4'b0010, rand_ops(), rand_ops());
        idle(8);
        req_valid = 4'b1001;
        #1;
        check("rr_wrap_first", req_ready, 4'b1000);
        cycle_step(4'b1001, rand_ops(), rand_ops());
        cycle_step(4'b1001, rand_ops(), rand_ops());
        idle(10);

        // Reset with three ops in flight, then a clean op afterwards.
        do_reset();
        cycle_step(4'b0001, rand_ops(), rand_ops());
        cycle_step(4'b0010, rand_ops(), rand_ops());
        cycle_step(4'b0100, rand_ops(), rand_ops());
        do_reset();
        idle(2);
        cycle_step(4'b0100, rand_ops(), rand_ops());
        idle(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 10000; i++) begin
            if (i == 4000 || i == 7777) do_reset();
            cycle_step(4'($urandom()), rand_ops(), rand_ops());
        end
        idle(10);
        check("drain_empty", sb_id.size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-002 Parameter WIDTH, default 35: operand width; product width is 2*WIDTH.
REQ-003 Parameter LATENCY, default 6: multiplier pipeline depth, from operands presented to product valid.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_ready  output  NREQ  per-requester accept; handshake when valid and ready are both high at a rising edge.
REQ-008 req_a, req_b  input  NREQ*WIDTH each  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 mul_a, mul_b  output  WIDTH each  registered operands to the shared multiplier.
REQ-010 mul_mm  input  2*WIDTH  multiplier product, valid LATENCY cycles after the operands.
REQ-011 rsp_valid  output  1  one-cycle result strobe.
REQ-012 rsp_id  output  clog2(NREQ)  requester index owning the result.
REQ-013 rsp_data  output  2*WIDTH  registered product.
REQ-014 busy  output  NREQ  outstanding flag per requester.

Function
REQ-015 At most one request shall be accepted per cycle; req_ready shall be one-hot or zero.
REQ-016 Requester i shall be eligible when req_valid[i]=1 and busy[i]=0; req_ready[i] shall be high only for the granted eligible requester (combinational from req_valid, busy and pointer).
REQ-017 Arbitration shall be round-robin: search starts at last-granted index +1 (mod NREQ); the pointer updates only on an accepted handshake.
REQ-018 On accept at edge k: mul_a/mul_b load the granted operands, busy[i] sets, and a tag (valid, id) enters a LATENCY-deep shift register.
REQ-019 With no accept at edge k, mul_a/mul_b shall hold their values and a tag with valid=0 shall enter the shift register.
REQ-020 At edge k+LATENCY+1: rsp_valid=1, rsp_id=tag id, rsp_data=mul_mm, busy[id] clears; total latency from accept to rsp_valid is LATENCY+1 (7 at default).
REQ-021 rsp_valid shall be high for exactly one cycle per accepted request, and results shall return in acceptance order.
REQ-022 A requester whose result strobes in a cycle shall be eligible in that same cycle (busy is already clear).
REQ-023 Back-to-back accepts from different requesters every cycle shall sustain one result per cycle with no bubbles.
REQ-024 req_valid deasserting without a handshake shall cancel the request with no side effects; operand changes while not accepted are ignored.
REQ-025 No result backpressure exists: the consumer shall take rsp_* in the strobe cycle.

Reset
REQ-026 While reset=0: req_ready=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, mul_a=0, mul_b=0, all tags invalid, pointer=NREQ-1 (requester 0 highest priority first).
REQ-027 Reset asserted mid-operation shall discard all in-flight tags; no rsp_valid shall appear for requests accepted before reset, even though the multiplier pipeline is not reset.
REQ-028 First accept shall be possible at the first rising edge after reset deasserts.

Verification
REQ-029 Single op: requester 0, a=0x5abcd, b=0x7adef, accepted edge 1 -> rsp_valid at edge 8, rsp_id=0, rsp_data=0x2B8CFFED63, busy[0] high edges 1-7.
REQ-030 All four valid continuously from reset -> grants 0,1,2,3 on consecutive edges, then none until each result; results return ids 0,1,2,3 on consecutive cycles.
REQ-031 Requester 2 valid while busy[2]=1 -> req_ready[2]=0 until its rsp_valid cycle, accepted at that edge.
REQ-032 Pointer at 1, requesters 0 and 3 valid -> requester 3 granted first, then 0.
REQ-033 Accept three ops, assert reset at edge 3 for one cycle -> no rsp_valid for them, all outputs at reset values, next op completes normally with latency 7.
REQ-034 Random stimulus over 10k cycles against a reference model -> every product correct, per-requester order kept, never two ops outstanding per requester.
